lcd_pattern_pipe: RTL and testbench

LCD_PATTERN_PIPE -- requirements
Module: lcd_pattern_pipe

---
 rtl/lcd_pattern_pipe.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_lcd_pattern_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_pipe.sv
// lcd_pattern_pipe
//   Test-pattern generator that sits behind an LCD timing generator.
//   Pixel coordinates and sync/DE strobes enter on every PIXEL_CLK edge
//   and leave two cycles later with an RGB565 pattern attached. A
//   debounced user button steps through four patterns. The new pattern
//   is committed only at the start of a frame, so no frame ever shows
//   two patterns.
//
// Parameters
//   H_ACTIVE        active pixels per line (coordinates at or beyond this are blanked)
//   V_ACTIVE        active lines per frame (rows at or beyond this are blanked)
//   DEBOUNCE_CYCLES consecutive stable samples needed to accept a button edge
//
// Ports
//   PIXEL_CLK  in   pixel clock; every register updates on its rising edge
//   RESET      in   synchronous active-high reset
//   HSYNC_IN   in   timing-generator HSYNC, active-low
//   VSYNC_IN   in   timing-generator VSYNC, active-low
//   DEN_IN     in   timing-generator data enable, active-high
//   XPOS/YPOS  in   current pixel column/row (11 bits)
//   BTN_USER   in   raw push button, active-low, asynchronous
//   HSYNC_OUT/VSYNC_OUT/DEN_OUT  out  strobes delayed to match pixel latency
//   LCD_R/LCD_G/LCD_B            out  RGB565 pixel
//   MODE                         out  pattern mode currently on screen
module lcd_pattern_pipe #(
  parameter int          H_ACTIVE        = 800,
  parameter int          V_ACTIVE        = 480,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        PIXEL_CLK,
  input  logic        RESET,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  input  logic        DEN_IN,
  input  logic [10:0] XPOS,
  input  logic [10:0] YPOS,
  input  logic        BTN_USER,
  output logic        HSYNC_OUT,
  output logic        VSYNC_OUT,
  output logic        DEN_OUT,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic [1:0]  MODE
);

  localparam logic [10:0] H_LIMIT = H_ACTIVE[10:0];
  localparam logic [10:0] V_LIMIT = V_ACTIVE[10:0];

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_WAIT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_WAIT_UP = 2'd3
  } db_state_t;

  // Stage 1: registered copy of the timing-generator inputs
  logic        hs_s1_reg;
  logic        vs_s1_reg;
  logic        den_s1_reg;
  logic [10:0] x_s1_reg;
  logic [10:0] y_s1_reg;

  // Stage 2: output registers
  logic        hs_s2_reg;
  logic        vs_s2_reg;
  logic        den_s2_reg;
  logic [4:0]  r_reg;
  logic [5:0]  g_reg;
  logic [4:0]  b_reg;

  // Pattern computed from stage 1
  logic [4:0]  r_next;
  logic [5:0]  g_next;
  logic [4:0]  b_next;
  logic        box_masked;
  logic        out_of_range;

  // Frame / mode state
  logic        frame_tick;
  logic [7:0]  box_x_reg;
  logic [7:0]  box_y_reg;
  logic [1:0]  mode_reg;
  logic [1:0]  mode_pending_reg;

  // Button path
  logic        btn_meta_reg;
  logic        btn_sync_reg;
  db_state_t   db_state_reg;
  logic [15:0] db_cnt_reg;
  logic [15:0] db_cnt_inc;
  logic        press_reg;

  // ------------------------------------------------------------------
  // Stage 1 capture
  // ------------------------------------------------------------------
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      hs_s1_reg  <= 1'b1;
      vs_s1_reg  <= 1'b1;
      den_s1_reg <= 1'b0;
      x_s1_reg   <= '0;
      y_s1_reg   <= '0;
    end else begin
      hs_s1_reg  <= HSYNC_IN;
      vs_s1_reg  <= VSYNC_IN;
      den_s1_reg <= DEN_IN;
      x_s1_reg   <= XPOS;
      y_s1_reg   <= YPOS;
    end
  end

  // Frame starts when the once-registered VSYNC falls; stage 2 holds
  // its previous value, so no extra edge-detect flop is needed.
  assign frame_tick = vs_s2_reg & ~vs_s1_reg;

  // ------------------------------------------------------------------
  // Pattern generation (between stage 1 and stage 2)
  // ------------------------------------------------------------------
  assign box_masked   = (x_s1_reg[7:0] < box_x_reg) || (y_s1_reg[7:0] < box_y_reg);
  assign out_of_range = (x_s1_reg >= H_LIMIT) || (y_s1_reg >= V_LIMIT);

  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    case (mode_reg)
      2'd0: begin
        if (!box_masked) begin
          r_next = {5{x_s1_reg[5] ^ y_s1_reg[5]}};
          g_next = {6{x_s1_reg[6] ^ y_s1_reg[6]}};
          b_next = {5{x_s1_reg[7] ^ y_s1_reg[7]}};
        end
      end
      2'd1: begin
        // Eight vertical bars, 128 pixels wide; bar index is XPOS[9:7]
        r_next = {5{x_s1_reg[9]}};
        g_next = {6{x_s1_reg[8]}};
        b_next = {5{x_s1_reg[7]}};
      end
      2'd2: begin
        if (!box_masked) begin
          r_next = x_s1_reg[8:4];
          g_next = y_s1_reg[8:3];
          b_next = box_x_reg[7:3];
        end
      end
      default: begin
        r_next = 5'h1F;
        g_next = 6'h3F;
        b_next = 5'h1F;
      end
    endcase
    // Blanking and out-of-range pixels override every pattern
    if (!den_s1_reg || out_of_range) begin
      r_next = '0;
      g_next = '0;
      b_next = '0;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2 / outputs
  // ------------------------------------------------------------------
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      hs_s2_reg  <= 1'b1;
      vs_s2_reg  <= 1'b1;
      den_s2_reg <= 1'b0;
      r_reg      <= '0;
      g_reg      <= '0;
      b_reg      <= '0;
    end else begin
      hs_s2_reg  <= hs_s1_reg;
      vs_s2_reg  <= vs_s1_reg;
      den_s2_reg <= den_s1_reg;
      r_reg      <= r_next;
      g_reg      <= g_next;
      b_reg      <= b_next;
    end
  end

  // ------------------------------------------------------------------
  // Moving box and mode commit
  // ------------------------------------------------------------------
  // mode_reg samples mode_pending_reg before the press increment lands,
  // so a press coinciding with a frame tick shows up one frame later.
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      box_x_reg        <= '0;
      box_y_reg        <= '0;
      mode_reg         <= '0;
      mode_pending_reg <= '0;
    end else begin
      if (press_reg) begin
        mode_pending_reg <= mode_pending_reg + 2'd1;
      end
      if (frame_tick) begin
        mode_reg  <= mode_pending_reg;
        box_x_reg <= box_x_reg + 8'd1;
        box_y_reg <= box_y_reg + 8'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Button synchronizer and debounce
  // ------------------------------------------------------------------
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      btn_meta_reg <= 1'b1;
      btn_sync_reg <= 1'b1;
    end else begin
      btn_meta_reg <= BTN_USER;
      btn_sync_reg <= btn_meta_reg;
    end
  end

  // Saturating increment so a very long stable level never wraps back
  // below the threshold.
  assign db_cnt_inc = (db_cnt_reg == 16'hFFFF) ? db_cnt_reg : db_cnt_reg + 16'd1;

  // The sample that leaves UP/DOWN counts as the first stable sample,
  // so the counter starts at 1 on entry to the WAIT states.
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      db_state_reg <= ST_UP;
      db_cnt_reg   <= '0;
      press_reg    <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      case (db_state_reg)
        ST_UP: begin
          if (!btn_sync_reg) begin
            db_state_reg <= ST_WAIT_DN;
            db_cnt_reg   <= 16'd1;
          end else begin
            db_cnt_reg   <= '0;
          end
        end
        ST_WAIT_DN: begin
          if (btn_sync_reg) begin
            db_state_reg <= ST_UP;
            db_cnt_reg   <= '0;
          end else if (db_cnt_inc >= DEBOUNCE_CYCLES) begin
            db_state_reg <= ST_DOWN;
            db_cnt_reg   <= '0;
            press_reg    <= 1'b1;
          end else begin
            db_cnt_reg   <= db_cnt_inc;
          end
        end
        ST_DOWN: begin
          if (btn_sync_reg) begin
            db_state_reg <= ST_WAIT_UP;
            db_cnt_reg   <= 16'd1;
          end else begin
            db_cnt_reg   <= '0;
          end
        end
        ST_WAIT_UP: begin
          if (!btn_sync_reg) begin
            db_state_reg <= ST_DOWN;
            db_cnt_reg   <= '0;
          end else if (db_cnt_inc >= DEBOUNCE_CYCLES) begin
            db_state_reg <= ST_UP;
            db_cnt_reg   <= '0;
          end else begin
            db_cnt_reg   <= db_cnt_inc;
          end
        end
        default: begin
          db_state_reg <= ST_UP;
          db_cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign HSYNC_OUT = hs_s2_reg;
  assign VSYNC_OUT = vs_s2_reg;
  assign DEN_OUT   = den_s2_reg;
  assign LCD_R     = r_reg;
  assign LCD_G     = g_reg;
  assign LCD_B     = b_reg;
  assign MODE      = mode_reg;

endmodule

// File: tb/tb_lcd_pattern_pipe.sv
// Self-checking bench for lcd_pattern_pipe: directed scenarios plus
// randomized pixel streams compared with a coordinate-arithmetic model.
module tb_lcd_pattern_pipe;

  localparam int H_ACT = 800;
  localparam int V_ACT = 480;
  localparam int DB    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync_in, vsync_in, den_in, btn;
  logic [10:0] xpos, ypos;
  logic        hsync_out, vsync_out, den_out;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;
  logic [1:0]  mode;

  int checks = 0;
  int passes = 0;

  // Reference state kept by the bench
  int m_mode    = 0;
  int m_pending = 0;
  int m_box     = 0;
  int press_seen = 0;

  always #5 clk = ~clk;

  lcd_pattern_pipe #(
    .H_ACTIVE(H_ACT),
    .V_ACTIVE(V_ACT),
    .DEBOUNCE_CYCLES(16'(DB))
  ) dut (
    .PIXEL_CLK(clk),
    .RESET(rst),
    .HSYNC_IN(hsync_in),
    .VSYNC_IN(vsync_in),
    .DEN_IN(den_in),
    .XPOS(xpos),
    .YPOS(ypos),
    .BTN_USER(btn),
    .HSYNC_OUT(hsync_out),
    .VSYNC_OUT(vsync_out),
    .DEN_OUT(den_out),
    .LCD_R(lcd_r),
    .LCD_G(lcd_g),
    .LCD_B(lcd_b),
    .MODE(mode)
  );

  always @(negedge clk) if (dut.press_reg === 1'b1) press_seen++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, checks so far %0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Pattern model: plain integer arithmetic on the pixel coordinates
  function automatic logic [15:0] model_rgb(input int x, input int y, input bit den,
                                            input int md, input int box);
    int r, g, b;
    bit masked;
    r = 0; g = 0; b = 0;
    masked = ((x % 256) < box) || ((y % 256) < box);
    if (den && x < H_ACT && y < V_ACT) begin
      case (md)
        0: if (!masked) begin
             r = (((x / 32) % 2) != ((y / 32) % 2)) ? 31 : 0;
             g = (((x / 64) % 2) != ((y / 64) % 2)) ? 63 : 0;
             b = (((x / 128) % 2) != ((y / 128) % 2)) ? 31 : 0;
           end
        1: begin
             r = (((x / 128) % 8) >= 4) ? 31 : 0;
             g = ((((x / 128) % 8) / 2) % 2 == 1) ? 63 : 0;
             b = (((x / 128) % 8) % 2 == 1) ? 31 : 0;
           end
        2: if (!masked) begin
             r = (x / 16) % 32;
             g = (y / 8) % 64;
             b = box / 8;
           end
        default: begin r = 31; g = 63; b = 31; end
      endcase
    end
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  task automatic idle_inputs();
    hsync_in = 1'b1; vsync_in = 1'b1; den_in = 1'b0; xpos = '0; ypos = '0;
  endtask

  // One frame: a VSYNC falling edge, then back high
  task automatic do_frame();
    @(posedge clk); #1;
    den_in = 1'b0; vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_mode = m_pending;
    m_box  = (m_box + 1) % 256;
  endtask

  // Hold the button low for low_cycles samples, then release and let it settle
  task automatic press_btn(input int low_cycles);
    @(posedge clk); #1 btn = 1'b0;
    repeat (low_cycles) @(posedge clk);
    #1 btn = 1'b1;
    repeat (DB + 8) @(posedge clk);
    #1;
    if (low_cycles >= DB + 2) m_pending = (m_pending + 1) % 4;
  endtask

  task automatic set_mode(input int target, input int frames);
    while (m_pending != target) press_btn(DB + 5);
    repeat (frames) do_frame();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; den_in = 1'b1;
    xpos = 11'd32; ypos = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    $display("reset: hs=%b vs=%b de=%b rgb=%h mode=%0d", hsync_out, vsync_out, den_out,
             {lcd_r, lcd_g, lcd_b}, mode);
    checks++; if ({hsync_out, vsync_out, den_out} !== 3'b110) $display("FAIL reset_sync: got %b want 110", {hsync_out, vsync_out, den_out}); else passes++;
    checks++; if ({lcd_r, lcd_g, lcd_b} !== 16'h0) $display("FAIL reset_rgb: got %h want 0000", {lcd_r, lcd_g, lcd_b}); else passes++;
    checks++; if (mode !== 2'd0) $display("FAIL reset_mode: got %0d want 0", mode); else passes++;
    checks++; if (dut.box_x_reg !== 8'd0) $display("FAIL reset_box: got %0d want 0", dut.box_x_reg); else passes++;
    idle_inputs(); btn = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_mode = 0; m_pending = 0; m_box = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_first_pixel();
    den_in = 1'b1; xpos = 11'd32; ypos = 11'd0;
    @(posedge clk); #1 idle_inputs();
    @(posedge clk); #1;
    $display("first pixel: de=%b r=%h g=%h b=%h", den_out, lcd_r, lcd_g, lcd_b);
    checks++; if (den_out !== 1'b1) $display("FAIL first_den: got %b want 1", den_out); else passes++;
    checks++; if ({lcd_r, lcd_g, lcd_b} !== {5'h1F, 6'h00, 5'h00}) $display("FAIL first_rgb: got %h want %h", {lcd_r, lcd_g, lcd_b}, {5'h1F, 6'h00, 5'h00}); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_box_wrap();
    int bad;
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      do_frame();
      checks++;
      if (dut.box_x_reg !== 8'(i % 256) || dut.box_y_reg !== 8'(i % 256)) begin
        $display("FAIL box_step%0d: got x=%0d y=%0d want %0d", i, dut.box_x_reg, dut.box_y_reg, i % 256);
        bad++;
      end else passes++;
    end
    $display("box wrap: 256 frames, box_x now %0d", dut.box_x_reg);
  endtask

  task automatic test_debounce();
    int p0;
    p0 = press_seen;
    press_btn(DB - 1);
    do_frame();
    $display("short press: pulses=%0d mode=%0d", press_seen - p0, mode);
    checks++; if (press_seen - p0 !== 0) $display("FAIL short_pulse: got %0d want 0", press_seen - p0); else passes++;
    checks++; if (mode !== 2'(m_mode)) $display("FAIL short_mode: got %0d want %0d", mode, m_mode); else passes++;
    p0 = press_seen;
    press_btn(DB + 5);
    $display("long press: pulses=%0d mode=%0d", press_seen - p0, mode);
    checks++; if (press_seen - p0 !== 1) $display("FAIL long_pulse: got %0d want 1", press_seen - p0); else passes++;
    checks++; if (mode !== 2'(m_mode)) $display("FAIL long_mode_before_tick: got %0d want %0d", mode, m_mode); else passes++;
    do_frame();
    checks++; if (mode !== 2'(m_mode) || m_mode != 1) $display("FAIL long_mode_after_tick: got %0d want 1 (model %0d)", mode, m_mode); else passes++;
  endtask

  task automatic run_pixels(input int md, input int n);
    logic [15:0] exp_q[$];
    logic [2:0]  ctl_q[$];
    logic [15:0] e_rgb;
    logic [2:0]  e_ctl;
    int x, y, errs;
    bit d, h;
    errs = 0;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (i >= 2) begin
        e_rgb = exp_q.pop_front();
        e_ctl = ctl_q.pop_front();
        checks++;
        if ({lcd_r, lcd_g, lcd_b} !== e_rgb) begin
          $display("FAIL pix_mode%0d_%0d: got %h want %h", md, i - 2, {lcd_r, lcd_g, lcd_b}, e_rgb);
          errs++;
        end else passes++;
        checks++;
        if ({hsync_out, vsync_out, den_out} !== e_ctl) begin
          $display("FAIL ctl_mode%0d_%0d: got %b want %b", md, i - 2, {hsync_out, vsync_out, den_out}, e_ctl);
          errs++;
        end else passes++;
      end
      if (i < n) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 600);
        d = ($urandom_range(0, 7) != 0);
        h = 1'($urandom_range(0, 1));
        xpos = 11'(x); ypos = 11'(y); den_in = d; hsync_in = h; vsync_in = 1'b1;
        exp_q.push_back(model_rgb(x, y, d, m_mode, m_box));
        ctl_q.push_back({h, 1'b1, d});
      end else idle_inputs();
    end
    $display("pixel stream: mode=%0d box=%0d pixels=%0d errors=%0d", md, m_box, n, errs);
  endtask

  task automatic test_modes();
    for (int md = 0; md < 4; md++) begin
      set_mode(md, $urandom_range(1, 100));
      checks++; if (mode !== 2'(md)) $display("FAIL mode_select: got %0d want %0d", mode, md); else passes++;
      run_pixels(md, 80);
    end
  endtask

  task automatic test_bars();
    set_mode(1, 1);
    den_in = 1'b1; xpos = 11'd640; ypos = 11'd10;
    @(posedge clk); #1 idle_inputs();
    @(posedge clk); #1;
    $display("bars x=640: rgb=%h", {lcd_r, lcd_g, lcd_b});
    checks++; if ({lcd_r, lcd_g, lcd_b} !== {5'h1F, 6'h00, 5'h1F}) $display("FAIL bar5: got %h want %h", {lcd_r, lcd_g, lcd_b}, {5'h1F, 6'h00, 5'h1F}); else passes++;
    den_in = 1'b0; xpos = 11'd640; ypos = 11'd10;
    @(posedge clk); #1 idle_inputs();
    @(posedge clk); #1;
    $display("bars x=640 de=0: rgb=%h de=%b", {lcd_r, lcd_g, lcd_b}, den_out);
    checks++; if ({den_out, lcd_r, lcd_g, lcd_b} !== 17'h0) $display("FAIL bar_blank: got %b/%h want 0/0000", den_out, {lcd_r, lcd_g, lcd_b}); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat, tl;
    bit found;
    // Measure press latency from the button edge
    lat = DB + 2; found = 0;
    @(posedge clk); #1 btn = 1'b0;
    for (int k = 1; k <= DB + 20; k++) begin
      @(posedge clk); #1;
      if (!found && dut.press_reg === 1'b1) begin lat = k; found = 1; end
    end
    btn = 1'b1;
    m_pending = (m_pending + 1) % 4;
    checks++; if (!found) $display("FAIL press_timeout: got none want pulse within %0d", DB + 20); else passes++;
    repeat (DB + 8) @(posedge clk);
    // Measure frame-tick latency from the VSYNC edge
    tl = 1; found = 0;
    @(posedge clk); #1 vsync_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (!found && dut.frame_tick === 1'b1) begin tl = k; found = 1; end
    end
    vsync_in = 1'b1;
    m_mode = m_pending; m_box = (m_box + 1) % 256;
    checks++; if (!found) $display("FAIL tick_timeout: got none want tick within 6"); else passes++;
    repeat (3) @(posedge clk); #1;
    while (m_pending != 2) press_btn(DB + 5);
    // Press and frame tick land in the same cycle
    @(posedge clk); #1 btn = 1'b0;
    if (lat - tl == 0) vsync_in = 1'b0;
    for (int k = 1; k <= lat + 4; k++) begin
      @(posedge clk); #1;
      if (k == lat - tl) vsync_in = 1'b0;
      if (k == lat - tl + 3) vsync_in = 1'b1;
      if (k == lat) begin
        checks++;
        if ({dut.press_reg, dut.frame_tick} !== 2'b11) $display("FAIL coincide: got %b want 11", {dut.press_reg, dut.frame_tick}); else passes++;
      end
    end
    vsync_in = 1'b1; btn = 1'b1;
    m_mode = m_pending; m_pending = (m_pending + 1) % 4; m_box = (m_box + 1) % 256;
    $display("coincident press+tick: mode=%0d", mode);
    checks++; if (mode !== 2'd2) $display("FAIL coincide_mode: got %0d want 2", mode); else passes++;
    repeat (DB + 8) @(posedge clk); #1;
    do_frame();
    $display("next frame: mode=%0d", mode);
    checks++; if (mode !== 2'd3) $display("FAIL coincide_next: got %0d want 3", mode); else passes++;
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = press_seen;
    @(posedge clk); #1 btn = 1'b0;
    repeat (DB / 2 + 3) @(posedge clk);
    #1;
    rst = 1'b1; btn = 1'b1;
    hsync_in = 1'b0; den_in = 1'b1; xpos = 11'd32; ypos = 11'd0;
    @(posedge clk); #1;
    $display("mid reset: hs=%b vs=%b de=%b rgb=%h mode=%0d", hsync_out, vsync_out, den_out,
             {lcd_r, lcd_g, lcd_b}, mode);
    checks++; if ({hsync_out, vsync_out, den_out} !== 3'b110) $display("FAIL mid_sync: got %b want 110", {hsync_out, vsync_out, den_out}); else passes++;
    checks++; if ({lcd_r, lcd_g, lcd_b} !== 16'h0) $display("FAIL mid_rgb: got %h want 0000", {lcd_r, lcd_g, lcd_b}); else passes++;
    checks++; if (mode !== 2'd0) $display("FAIL mid_mode: got %0d want 0", mode); else passes++;
    rst = 1'b0; idle_inputs();
    m_mode = 0; m_pending = 0; m_box = 0;
    repeat (DB + 10) @(posedge clk); #1;
    checks++; if (press_seen - p0 !== 0) $display("FAIL mid_pulse: got %0d want 0", press_seen - p0); else passes++;
    do_frame();
    $display("first frame after reset: box_x=%0d box_y=%0d mode=%0d", dut.box_x_reg, dut.box_y_reg, mode);
    checks++; if ({dut.box_x_reg, dut.box_y_reg} !== {8'd1, 8'd1}) $display("FAIL mid_box: got %0d/%0d want 1/1", dut.box_x_reg, dut.box_y_reg); else passes++;
    checks++; if (mode !== 2'd0) $display("FAIL mid_mode_after: got %0d want 0", mode); else passes++;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1; btn = 1'b1;
    test_reset();
    test_first_pixel();
    test_box_wrap();
    test_debounce();
    test_modes();
    test_bars();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
